// File: rtl/pbus_seq.sv
// pbus_seq: round-robin sequencer for the shared W5300/SL811 peripheral bus.
// Two byte-access requesters are granted in turn. Each access runs SETUP -> STROBE -> HOLD
// with per-chip timing. Read data is captured on the last strobe edge.
module pbus_seq #(
    parameter int unsigned W_SETUP = 1,
    parameter int unsigned W_PULSE = 3,
    parameter int unsigned S_SETUP = 1,
    parameter int unsigned S_PULSE = 4,
    parameter int unsigned T_HOLD  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic       rnw0,
    input  logic       rnw1,
    input  logic       tgt0,
    input  logic       tgt1,
    input  logic [9:0] addr0,
    input  logic [9:0] addr1,
    input  logic [7:0] wd0,
    input  logic [7:0] wd1,
    output logic       done0,
    output logic       done1,
    output logic [7:0] rdata,
    output logic [9:0] bus_addr,
    output logic [7:0] bus_dout,
    output logic       bus_oe,
    input  logic [7:0] bus_din,
    output logic       brd_n,
    output logic       bwr_n,
    output logic       w5300_cs_n,
    output logic       sl811_cs_n
);

    // Counter load values are duration-1. A zero setup/pulse is stretched to one cycle.
    localparam logic [3:0] W_SU_LD = (W_SETUP == 0) ? 4'd0 : 4'(W_SETUP - 1);
    localparam logic [3:0] W_PU_LD = (W_PULSE == 0) ? 4'd0 : 4'(W_PULSE - 1);
    localparam logic [3:0] S_SU_LD = (S_SETUP == 0) ? 4'd0 : 4'(S_SETUP - 1);
    localparam logic [3:0] S_PU_LD = (S_PULSE == 0) ? 4'd0 : 4'(S_PULSE - 1);
    localparam logic [3:0] HO_LD   = (T_HOLD  == 0) ? 4'd0 : 4'(T_HOLD - 1);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic       cur_ch, cur_ch_nx;
    logic       rnw_q, rnw_nx;
    logic       tgt_q, tgt_nx;
    logic       last_grant, last_grant_nx;
    logic       done0_nx, done1_nx;
    logic [7:0] rdata_nx;
    logic [9:0] bus_addr_nx;
    logic [7:0] bus_dout_nx;
    logic       bus_oe_nx, brd_n_nx, bwr_n_nx, w5300_cs_n_nx, sl811_cs_n_nx;
    logic       finish, grant_ok, el0, el1, pick;

    // State, latched access and all bus outputs are registered; reset forces the bus idle at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            cur_ch     <= 1'b0;
            rnw_q      <= 1'b1;
            tgt_q      <= 1'b0;
            last_grant <= 1'b1;
            done0      <= 1'b0;
            done1      <= 1'b0;
            rdata      <= '0;
            bus_addr   <= '0;
            bus_dout   <= '0;
            bus_oe     <= 1'b0;
            brd_n      <= 1'b1;
            bwr_n      <= 1'b1;
            w5300_cs_n <= 1'b1;
            sl811_cs_n <= 1'b1;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            cur_ch     <= cur_ch_nx;
            rnw_q      <= rnw_nx;
            tgt_q      <= tgt_nx;
            last_grant <= last_grant_nx;
            done0      <= done0_nx;
            done1      <= done1_nx;
            rdata      <= rdata_nx;
            bus_addr   <= bus_addr_nx;
            bus_dout   <= bus_dout_nx;
            bus_oe     <= bus_oe_nx;
            brd_n      <= brd_n_nx;
            bwr_n      <= bwr_n_nx;
            w5300_cs_n <= w5300_cs_n_nx;
            sl811_cs_n <= sl811_cs_n_nx;
        end
    end

    // Next state, arbitration and next bus-output values.
    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        cur_ch_nx     = cur_ch;
        rnw_nx        = rnw_q;
        tgt_nx        = tgt_q;
        last_grant_nx = last_grant;
        rdata_nx      = rdata;
        bus_addr_nx   = bus_addr;
        bus_dout_nx   = bus_dout;
        done0_nx      = 1'b0;
        done1_nx      = 1'b0;
        bus_oe_nx     = 1'b0;
        brd_n_nx      = 1'b1;
        bwr_n_nx      = 1'b1;
        w5300_cs_n_nx = 1'b1;
        sl811_cs_n_nx = 1'b1;
        finish        = 1'b0;
        grant_ok      = 1'b0;
        pick          = 1'b0;

        case (state)
            IDLE: grant_ok = 1'b1;
            SETUP: begin
                if (cnt == 4'd0) begin
                    state_nx = STROBE;
                    cnt_nx   = tgt_q ? S_PU_LD : W_PU_LD;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            STROBE: begin
                if (cnt == 4'd0) begin
                    if (rnw_q) rdata_nx = bus_din;
                    if (T_HOLD != 0) begin
                        state_nx = HOLD;
                        cnt_nx   = HO_LD;
                    end else begin
                        finish = 1'b1;
                    end
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            HOLD: begin
                if (cnt == 4'd0) finish = 1'b1;
                else             cnt_nx = cnt - 4'd1;
            end
            default: state_nx = IDLE;
        endcase

        if (finish) begin
            state_nx = IDLE;
            done0_nx = !cur_ch;
            done1_nx = cur_ch;
            grant_ok = 1'b1;
        end

        // A requester keeps req high until it has seen its done, so the channel just finishing
        // (or whose done is showing in IDLE) is not eligible; this allows a gapless grant to the other.
        el0 = req0 && !((finish && !cur_ch) || (state == IDLE && done0));
        el1 = req1 && !((finish &&  cur_ch) || (state == IDLE && done1));

        if (grant_ok && (el0 || el1)) begin
            pick          = (el0 && el1) ? !last_grant : el1;
            last_grant_nx = pick;
            cur_ch_nx     = pick;
            rnw_nx        = pick ? rnw1 : rnw0;
            tgt_nx        = pick ? tgt1 : tgt0;
            bus_addr_nx   = pick ? addr1 : addr0;
            if (!rnw_nx) bus_dout_nx = pick ? wd1 : wd0;
            state_nx      = SETUP;
            cnt_nx        = tgt_nx ? S_SU_LD : W_SU_LD;
        end

        if (state_nx != IDLE) begin
            w5300_cs_n_nx = tgt_nx;
            sl811_cs_n_nx = !tgt_nx;
            bus_oe_nx     = !rnw_nx;
        end
        if (state_nx == STROBE) begin
            brd_n_nx = !rnw_nx;
            bwr_n_nx = rnw_nx;
        end
    end

endmodule
